program_sequencer: RTL and testbench

//   Instruction-issue stage upstream of the basic CPU (top). Holds a small

---
 rtl/program_sequencer.sv | 161 ++++++++++++++++
 tb/tb_program_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Instruction-issue stage for the basic CPU: holds a small program memory,
// fetches by PC, drives Din/run per instruction and waits for done.
module program_sequencer #(
    parameter int unsigned WORD    = 16,
    parameter int unsigned AW      = 6,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [WORD-1:0] prog_wdata,
    input  logic            start,
    output logic [WORD-1:0] proc_din,
    output logic            proc_run,
    input  logic            proc_done,
    output logic            busy,
    output logic            halted,
    output logic            error,
    output logic [AW-1:0]   pc,
    output logic [15:0]     issued_cnt
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned WDW   = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  OP_MVI  = 3'b100;
    localparam logic [2:0]  OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DRIVE_I,
        S_DRIVE_D,
        S_WAIT,
        S_HALT
    } state_t;

    state_t          state;
    logic [2:0]      op;
    logic [WDW-1:0]  watchdog;
    logic [WDW-1:0]  wd_inc;
    logic [WORD-1:0] mem [DEPTH];
    logic [WORD-1:0] mem_q;
    logic [WORD-1:0] rd_word;
    logic [AW-1:0]   rd_addr;
    logic [AW:0]     pc_adv;
    logic            done_ok;

    // Single read port: instruction word in FETCH, immediate word in DRIVE_I
    always_comb begin
        rd_addr = (state == S_DRIVE_I) ? pc + AW'(1) : pc;
        rd_word = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem[prog_addr] <= prog_wdata;
        end
        mem_q <= rd_word;
    end

    // One extra bit so running past the last address is visible as the MSB
    always_comb begin
        pc_adv  = {1'b0, pc} + ((op == OP_MVI) ? (AW + 1)'(2) : (AW + 1)'(1));
        wd_inc  = watchdog + WDW'(1);
        done_ok = proc_done && (state == S_WAIT || state == S_DRIVE_D);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op         <= 3'b000;
            pc         <= '0;
            proc_din   <= '0;
            proc_run   <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            error      <= 1'b0;
            issued_cnt <= '0;
            watchdog   <= '0;
        end else if (done_ok) begin
            proc_run <= 1'b0;
            watchdog <= '0;
            pc       <= pc_adv[AW-1:0];
            if (issued_cnt != 16'hFFFF) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
            if (pc_adv[AW]) begin
                state  <= S_HALT;
                halted <= 1'b1;
                busy   <= 1'b0;
            end else begin
                state <= S_FETCH;
            end
        end else begin
            proc_run <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state      <= S_FETCH;
                        pc         <= '0;
                        issued_cnt <= '0;
                        watchdog   <= '0;
                        halted     <= 1'b0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    op <= mem_q[8:6];
                    if (mem_q[8:6] == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else if (mem_q[8:6] == OP_MVI && pc == AW'(DEPTH - 1)) begin
                        state  <= S_HALT;
                        error  <= 1'b1;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state    <= S_DRIVE_I;
                        proc_din <= mem_q;
                        proc_run <= 1'b1;
                    end
                end
                S_DRIVE_I: begin
                    watchdog <= '0;
                    if (op == OP_MVI) begin
                        state    <= S_DRIVE_D;
                        proc_din <= rd_word;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_DRIVE_D: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wd_inc == WDW'(TIMEOUT)) begin
                        state    <= S_HALT;
                        error    <= 1'b1;
                        halted   <= 1'b1;
                        busy     <= 1'b0;
                        watchdog <= '0;
                    end else begin
                        watchdog <= wd_inc;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a small CPU responder that
// answers each run pulse with done a fixed number of cycles later.
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [15:0] prog_wdata;
    logic        start;
    logic [15:0] proc_din;
    logic        proc_run;
    logic        proc_done;
    logic        busy;
    logic        halted;
    logic        error;
    logic [5:0]  pc;
    logic [15:0] issued_cnt;

    int checks = 0;
    int failures = 0;

    int          runs, wide_runs, first_run, halt_cyc;
    logic [15:0] run_din [$];
    logic [15:0] after_din [$];
    logic [5:0]  pc_at1, pc_after_inj;
    logic        err_at1, halted_at1;

    program_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .proc_din   (proc_din),
        .proc_run   (proc_run),
        .proc_done  (proc_done),
        .busy       (busy),
        .halted     (halted),
        .error      (error),
        .pc         (pc),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic prog_write(input logic [5:0] a, input logic [15:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Pulse start, then play the CPU until busy drops or the budget runs out.
    // delay=0 means the CPU never answers. inj_cyc>0 pulses start and a write
    // of HALT to address 1 during that cycle.
    task automatic run_prog(input int delay, input int budget, input int inj_cyc);
        int   cyc;
        int   cd;
        logic prev_run;
        runs = 0; wide_runs = 0; first_run = -1; halt_cyc = -1;
        run_din.delete(); after_din.delete();
        cd = 0; prev_run = 1'b0; pc_after_inj = 6'h3F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc <= budget) begin
            prog_we = 1'b0; start = 1'b0; proc_done = 1'b0;
            if (cyc == 1) begin
                pc_at1 = pc; err_at1 = error; halted_at1 = halted;
            end
            if (cyc == inj_cyc + 1) pc_after_inj = pc;
            if (prev_run) after_din.push_back(proc_din);
            if (!busy) begin
                halt_cyc = cyc;
                break;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) proc_done = 1'b1;
            end
            if (proc_run) begin
                runs++;
                run_din.push_back(proc_din);
                if (prev_run) wide_runs++;
                if (first_run < 0) first_run = cyc;
                if (delay > 0) cd = delay;
            end
            prev_run = proc_run;
            if (cyc == inj_cyc) begin
                prog_we = 1'b1; prog_addr = 6'd1; prog_wdata = 16'h01C0; start = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        prog_we = 1'b0; start = 1'b0; proc_done = 1'b0;
    endtask

    function automatic logic [15:0] qget(input int which, input int idx);
        if (which == 0) return (idx < run_din.size()) ? run_din[idx] : 16'hDEAD;
        return (idx < after_din.size()) ? after_din[idx] : 16'hDEAD;
    endfunction

    task automatic test_reset();
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (halted !== 1'b0)      begin failures++; $display("FAIL rst_halted got=%0h exp=0", halted); end
        checks++; if (error !== 1'b0)       begin failures++; $display("FAIL rst_error got=%0h exp=0", error); end
        checks++; if (pc !== 6'd0)          begin failures++; $display("FAIL rst_pc got=%0h exp=0", pc); end
        checks++; if (proc_run !== 1'b0)    begin failures++; $display("FAIL rst_run got=%0h exp=0", proc_run); end
        checks++; if (proc_din !== 16'h0)   begin failures++; $display("FAIL rst_din got=%0h exp=0", proc_din); end
        checks++; if (issued_cnt !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", issued_cnt); end
    endtask

    task automatic load_mvi_prog();
        prog_write(6'd0, 16'h0100);
        prog_write(6'd1, 16'h0006);
        prog_write(6'd2, 16'h01C0);
    endtask

    task automatic check_mvi_result(input string tag);
        checks++; if (first_run !== 3)            begin failures++; $display("FAIL %s_latency got=%0d exp=3", tag, first_run); end
        checks++; if (runs !== 1)                 begin failures++; $display("FAIL %s_runs got=%0d exp=1", tag, runs); end
        checks++; if (qget(0, 0) !== 16'h0100)    begin failures++; $display("FAIL %s_din_instr got=%0h exp=0100", tag, qget(0, 0)); end
        checks++; if (qget(1, 0) !== 16'h0006)    begin failures++; $display("FAIL %s_din_imm got=%0h exp=0006", tag, qget(1, 0)); end
        checks++; if (pc !== 6'd2)                begin failures++; $display("FAIL %s_pc got=%0d exp=2", tag, pc); end
        checks++; if (issued_cnt !== 16'd1)       begin failures++; $display("FAIL %s_cnt got=%0d exp=1", tag, issued_cnt); end
        checks++; if (halted !== 1'b1)            begin failures++; $display("FAIL %s_halted got=%0h exp=1", tag, halted); end
        checks++; if (error !== 1'b0)             begin failures++; $display("FAIL %s_error got=%0h exp=0", tag, error); end
        checks++; if (halt_cyc !== 8)             begin failures++; $display("FAIL %s_halt_cyc got=%0d exp=8", tag, halt_cyc); end
    endtask

    task automatic test_mvi();
        load_mvi_prog();
        run_prog(2, 100, -1);
        check_mvi_result("mvi");
    endtask

    task automatic check_two_instr(input string tag);
        checks++; if (runs !== 2)              begin failures++; $display("FAIL %s_runs got=%0d exp=2", tag, runs); end
        checks++; if (wide_runs !== 0)         begin failures++; $display("FAIL %s_run_width got=%0d exp=0", tag, wide_runs); end
        checks++; if (qget(0, 0) !== 16'h0048) begin failures++; $display("FAIL %s_din0 got=%0h exp=0048", tag, qget(0, 0)); end
        checks++; if (qget(0, 1) !== 16'h0081) begin failures++; $display("FAIL %s_din1 got=%0h exp=0081", tag, qget(0, 1)); end
        checks++; if (qget(1, 0) !== 16'h0048) begin failures++; $display("FAIL %s_din_hold got=%0h exp=0048", tag, qget(1, 0)); end
        checks++; if (issued_cnt !== 16'd2)    begin failures++; $display("FAIL %s_cnt got=%0d exp=2", tag, issued_cnt); end
        checks++; if (pc !== 6'd2)             begin failures++; $display("FAIL %s_pc got=%0d exp=2", tag, pc); end
        checks++; if (halt_cyc !== 13)         begin failures++; $display("FAIL %s_halt_cyc got=%0d exp=13", tag, halt_cyc); end
    endtask

    task automatic test_two_instr();
        prog_write(6'd0, 16'h0048);
        prog_write(6'd1, 16'h0081);
        prog_write(6'd2, 16'h01C0);
        run_prog(2, 100, -1);
        check_two_instr("two");
    endtask

    task automatic test_timeout();
        prog_write(6'd0, 16'h0048);
        prog_write(6'd1, 16'h01C0);
        run_prog(0, 100, -1);
        checks++; if (halt_cyc !== 19)      begin failures++; $display("FAIL to_halt_cyc got=%0d exp=19", halt_cyc); end
        checks++; if (error !== 1'b1)       begin failures++; $display("FAIL to_error got=%0h exp=1", error); end
        checks++; if (halted !== 1'b1)      begin failures++; $display("FAIL to_halted got=%0h exp=1", halted); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL to_busy got=%0h exp=0", busy); end
        checks++; if (issued_cnt !== 16'd0) begin failures++; $display("FAIL to_cnt got=%0d exp=0", issued_cnt); end
        checks++; if (pc !== 6'd0)          begin failures++; $display("FAIL to_pc got=%0d exp=0", pc); end
        run_prog(2, 100, -1);
        checks++; if (err_at1 !== 1'b0)     begin failures++; $display("FAIL to_restart_err got=%0h exp=0", err_at1); end
        checks++; if (halted_at1 !== 1'b0)  begin failures++; $display("FAIL to_restart_halted got=%0h exp=0", halted_at1); end
        checks++; if (pc_at1 !== 6'd0)      begin failures++; $display("FAIL to_restart_pc got=%0d exp=0", pc_at1); end
        checks++; if (error !== 1'b0)       begin failures++; $display("FAIL to_rerun_error got=%0h exp=0", error); end
        checks++; if (pc !== 6'd1)          begin failures++; $display("FAIL to_rerun_pc got=%0d exp=1", pc); end
        checks++; if (issued_cnt !== 16'd1) begin failures++; $display("FAIL to_rerun_cnt got=%0d exp=1", issued_cnt); end
    endtask

    task automatic test_end_of_memory();
        for (int i = 0; i < 63; i++) prog_write(6'(i), 16'h0000);
        prog_write(6'd63, 16'h0100);
        run_prog(2, 1000, -1);
        checks++; if (halt_cyc !== 318)      begin failures++; $display("FAIL eom_mvi_halt_cyc got=%0d exp=318", halt_cyc); end
        checks++; if (runs !== 63)           begin failures++; $display("FAIL eom_mvi_runs got=%0d exp=63", runs); end
        checks++; if (issued_cnt !== 16'd63) begin failures++; $display("FAIL eom_mvi_cnt got=%0d exp=63", issued_cnt); end
        checks++; if (error !== 1'b1)        begin failures++; $display("FAIL eom_mvi_error got=%0h exp=1", error); end
        checks++; if (halted !== 1'b1)       begin failures++; $display("FAIL eom_mvi_halted got=%0h exp=1", halted); end
        checks++; if (pc !== 6'd63)          begin failures++; $display("FAIL eom_mvi_pc got=%0d exp=63", pc); end
        prog_write(6'd63, 16'h0000);
        run_prog(2, 1000, -1);
        checks++; if (halt_cyc !== 321)      begin failures++; $display("FAIL eom_nop_halt_cyc got=%0d exp=321", halt_cyc); end
        checks++; if (runs !== 64)           begin failures++; $display("FAIL eom_nop_runs got=%0d exp=64", runs); end
        checks++; if (issued_cnt !== 16'd64) begin failures++; $display("FAIL eom_nop_cnt got=%0d exp=64", issued_cnt); end
        checks++; if (error !== 1'b0)        begin failures++; $display("FAIL eom_nop_error got=%0h exp=0", error); end
        checks++; if (halted !== 1'b1)       begin failures++; $display("FAIL eom_nop_halted got=%0h exp=1", halted); end
        checks++; if (pc !== 6'd0)           begin failures++; $display("FAIL eom_nop_pc got=%0d exp=0", pc); end
    endtask

    task automatic test_reset_mid_run();
        load_mvi_prog();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL mid_busy got=%0h exp=1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL mid_rst_busy got=%0h exp=0", busy); end
        checks++; if (halted !== 1'b0)      begin failures++; $display("FAIL mid_rst_halted got=%0h exp=0", halted); end
        checks++; if (pc !== 6'd0)          begin failures++; $display("FAIL mid_rst_pc got=%0d exp=0", pc); end
        checks++; if (proc_din !== 16'h0)   begin failures++; $display("FAIL mid_rst_din got=%0h exp=0", proc_din); end
        checks++; if (proc_run !== 1'b0)    begin failures++; $display("FAIL mid_rst_run got=%0h exp=0", proc_run); end
        checks++; if (issued_cnt !== 16'h0) begin failures++; $display("FAIL mid_rst_cnt got=%0d exp=0", issued_cnt); end
        run_prog(2, 100, -1);
        check_mvi_result("mid_rerun");
    endtask

    task automatic test_busy_inputs();
        prog_write(6'd0, 16'h0048);
        prog_write(6'd1, 16'h0081);
        prog_write(6'd2, 16'h01C0);
        run_prog(2, 100, 7);
        checks++; if (pc_after_inj !== 6'd1) begin failures++; $display("FAIL busy_pc_after_start got=%0d exp=1", pc_after_inj); end
        check_two_instr("busy_inj");
        run_prog(2, 100, -1);
        check_two_instr("busy_rerun");
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        start = 1'b0; proc_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_mvi();
        test_two_instr();
        test_timeout();
        test_end_of_memory();
        test_reset_mid_run();
        test_busy_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
